// File: rtl/fb_pkg.sv
// Shared constants, state encoding and pixel packing for the frame-buffer writer.
package fb_pkg;
  localparam int unsigned HSIZE        = 640;
  localparam int unsigned VSIZE        = 480;
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned XW           = 10;
  localparam int unsigned YW           = 9;
  localparam int unsigned REVERSE_BASE = (VSIZE - 1) * HSIZE;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // RGB888 -> RGB565 by truncating the low bits of each channel.
  function automatic logic [15:0] pack565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction
endpackage

// File: rtl/fb_addr_gen.sv
// Pixel/line counters and line base register; flip mode walks lines bottom-up.
module fb_addr_gen
  import fb_pkg::ADDR_W, fb_pkg::XW, fb_pkg::YW;
#(
  parameter int unsigned HSIZE = fb_pkg::HSIZE,
  parameter int unsigned VSIZE = fb_pkg::VSIZE
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  input  logic              sof_i,
  input  logic              eol_i,
  input  logic              flip_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [XW-1:0]     x_o,
  output logic [YW-1:0]     y_o,
  output logic              line_end_o,
  output logic              frame_end_o,
  output logic              line_err_o
);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(HSIZE);
  localparam logic [ADDR_W-1:0] REV_BASE = ADDR_W'((VSIZE - 1) * HSIZE);
  localparam logic [XW-1:0]     X_LAST   = XW'(HSIZE - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(VSIZE - 1);

  logic [XW-1:0]     x_q, x_d, x_cur;
  logic [YW-1:0]     y_q, y_d, y_cur;
  logic [ADDR_W-1:0] base_q, base_d, base_cur;
  logic              flip_q, flip_d, flip_cur;
  logic              x_at_last;

  // A SOF beat is positioned as if the counters were already at the frame origin.
  always_comb begin
    x_cur    = sof_i ? '0 : x_q;
    y_cur    = sof_i ? '0 : y_q;
    flip_cur = sof_i ? flip_i : flip_q;
    base_cur = sof_i ? (flip_i ? REV_BASE : '0) : base_q;

    x_at_last   = (x_cur == X_LAST);
    line_end_o  = eol_i | x_at_last;
    frame_end_o = line_end_o & (y_cur == Y_LAST);
    line_err_o  = eol_i ^ x_at_last;
    addr_o      = base_cur + ADDR_W'(x_cur);

    x_d    = x_q;
    y_d    = y_q;
    base_d = base_q;
    flip_d = flip_q;
    if (step_i) begin
      flip_d = flip_cur;
      if (frame_end_o) begin
        x_d    = '0;
        y_d    = '0;
        base_d = '0;
      end else if (line_end_o) begin
        x_d    = '0;
        y_d    = y_cur + YW'(1);
        base_d = flip_cur ? (base_cur - H_STEP) : (base_cur + H_STEP);
      end else begin
        x_d    = x_cur + XW'(1);
        y_d    = y_cur;
        base_d = base_cur;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
      flip_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      base_q <= base_d;
      flip_q <= flip_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: rtl/fb_writer.sv
// Streams RGB888 pixel beats into an RGB565 frame buffer with optional vertical flip.
module fb_writer
  import fb_pkg::ADDR_W, fb_pkg::XW, fb_pkg::YW, fb_pkg::state_e, fb_pkg::ST_IDLE,
         fb_pkg::ST_ACTIVE, fb_pkg::pack565;
#(
  parameter int unsigned HSIZE = fb_pkg::HSIZE,
  parameter int unsigned VSIZE = fb_pkg::VSIZE
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [23:0]       S_DATA,
  input  logic              S_SOF,
  input  logic              S_EOL,
  input  logic              FREEZE,
  input  logic              Reverse_SW,
  output logic              BRAMWE,
  output logic [ADDR_W-1:0] BRAMWADDR,
  output logic [15:0]       BRAMWDATA,
  output logic              FRAME_DONE,
  output logic              ERR_LINE,
  output logic              ERR_SYNC
);
  state_e state_q, state_d;

  logic              xfer, wr, sync_err;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic              line_end, frame_end, line_err;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_line_q, err_line_d;
  logic              err_sync_q, err_sync_d;

  assign S_READY = !FREEZE;
  assign xfer    = S_VALID & S_READY;
  assign wr      = xfer & (S_SOF | (state_q == ST_ACTIVE));
  assign sync_err = xfer & S_SOF & (state_q == ST_ACTIVE) & ((x_cnt != '0) | (y_cnt != '0));

  fb_addr_gen #(
    .HSIZE(HSIZE),
    .VSIZE(VSIZE)
  ) u_addr_gen (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .step_i     (wr),
    .sof_i      (S_SOF),
    .eol_i      (S_EOL),
    .flip_i     (Reverse_SW),
    .addr_o     (addr),
    .x_o        (x_cnt),
    .y_o        (y_cnt),
    .line_end_o (line_end),
    .frame_end_o(frame_end),
    .line_err_o (line_err)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = wr;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = wr & frame_end;
    err_line_d = err_line_q | (wr & line_err);
    err_sync_d = err_sync_q | sync_err;
    if (wr) begin
      waddr_d = addr;
      wdata_d = pack565(S_DATA);
      state_d = frame_end ? ST_IDLE : ST_ACTIVE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_line_q <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_line_q <= err_line_d;
      err_sync_q <= err_sync_d;
    end
  end

  assign BRAMWE     = we_q;
  assign BRAMWADDR  = waddr_q;
  assign BRAMWDATA  = wdata_q;
  assign FRAME_DONE = done_q;
  assign ERR_LINE   = err_line_q;
  assign ERR_SYNC   = err_sync_q;
endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter HSIZE, default 640, active pixels per line.
REQ-002 Parameter VSIZE, default 480, active lines per frame.
REQ-003 CLK  input  1  single clock; all logic on its rising edge.
REQ-004 RESET_N  input  1  reset, synchronous, active-low.
REQ-005 S_VALID  input  1  pixel beat valid.
REQ-006 S_READY  output  1  fb_writer accepts beat; transfer = S_VALID & S_READY.
REQ-007 S_DATA  input  24  RGB888 pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 S_SOF  input  1  beat is first pixel of frame.
REQ-009 S_EOL  input  1  beat is last pixel of line.
REQ-010 FREEZE  input  1  backpressure request from display side.
REQ-011 Reverse_SW  input  1  vertical-flip write mode.
REQ-012 BRAMWE  output  1  BRAM write enable.
REQ-013 BRAMWADDR  output  19  BRAM write address (covers 640*480=307200).
REQ-014 BRAMWDATA  output  16  RGB565 write data.
REQ-015 FRAME_DONE  output  1  one-cycle pulse, last pixel of frame written.
REQ-016 ERR_LINE  output  1  sticky: line length mismatch seen.
REQ-017 ERR_SYNC  output  1  sticky: S_SOF arrived mid-frame.

Function
REQ-018 States IDLE (wait SOF), ACTIVE (writing); x counter 10 bits, y counter 9 bits, line base register 19 bits.
REQ-019 S_READY = !FREEZE, combinational; no other backpressure source.
REQ-020 IDLE: transfers without S_SOF are consumed and discarded (BRAMWE stays 0).
REQ-021 Transfer with S_SOF in any state: x=0, y=0, Reverse_SW sampled into flip flag, line base = 0 (flip=0) or (VSIZE-1)*HSIZE (flip=1, 306560 default); pixel written at that base; state -> ACTIVE.
REQ-022 S_SOF while ACTIVE and not at (x=0,y=0 expected) sets ERR_SYNC; frame restarts per REQ-021.
REQ-023 Reverse_SW changes mid-frame have no effect until the next S_SOF.
REQ-024 Write latency 1 cycle: accepted beat at edge N -> BRAMWE=1, BRAMWADDR=base+x, BRAMWDATA valid after edge N+1, held for one cycle only.
REQ-025 Pack: BRAMWDATA = {R[7:3],G[7:2],B[7:3]} (truncate, no rounding).
REQ-026 Non-EOL beat with x<HSIZE-1: x+1.
REQ-027 Line end (S_EOL beat, or x==HSIZE-1): x=0, y+1, base +HSIZE (flip=0) or -HSIZE (flip=1).
REQ-028 S_EOL with x<HSIZE-1 (short line) or x==HSIZE-1 without S_EOL (long line, forced wrap): set ERR_LINE; remaining pixels of short line left unwritten.
REQ-029 Line end with y==VSIZE-1: FRAME_DONE=1 in same cycle as that write; state -> IDLE; counters/base not used until next SOF.
REQ-030 Base arithmetic is unsigned 19-bit; no wrap occurs for legal frames; beats after frame end are discarded per REQ-020.
REQ-031 ERR_LINE/ERR_SYNC clear only on reset.
REQ-032 FREEZE asserted mid-line: no transfer, state/counters hold; resumes on deassert.

Reset
REQ-033 RESET_N low at rising edge: state IDLE, x=0, y=0, base=0, flip=0, BRAMWE=0, BRAMWADDR=0, BRAMWDATA=0, FRAME_DONE=0, ERR_LINE=0, ERR_SYNC=0.
REQ-034 Reset mid-frame abandons frame; no BRAM write on cycle after reset edge; partial frame not completed.
REQ-035 S_READY follows REQ-019 during reset; transfers during reset are ignored.

Structure
REQ-036 Package fb_pkg: HSIZE, VSIZE, ADDR_W=19, REVERSE_BASE=(VSIZE-1)*HSIZE, RGB888->RGB565 pack function, state enum.
REQ-037 One sub-module fb_addr_gen: x/y counters, base register, flip up/down step, line-end and frame-end flags.

Verification
REQ-038 Normal frame, Reverse_SW=0, 640x480 ramp: 307200 writes, first addr 0, pixel (5,2) at 1285, last addr 307199, FRAME_DONE once on last write.
REQ-039 Reverse_SW=1: first write addr 306560, line 1 starts at 305920, last write addr 639; toggling Reverse_SW mid-frame changes nothing.
REQ-040 Pack: S_DATA=0xFF8040 -> BRAMWDATA=0xFC08; 0x07FF07 -> 0x07E0.
REQ-041 Short line (S_EOL at x=99, line 0): ERR_LINE=1, next beat addr 640; long line (no EOL at x=639): ERR_LINE=1, wraps to 640.
REQ-042 SOF at (x=10,y=3): ERR_SYNC=1, that pixel written to addr 0; FREEZE=1 for 5 cycles: S_READY=0, no writes, addresses continue contiguously.
REQ-043 RESET_N low at pixel 1000: all outputs zero next cycle; beats without SOF discarded; next SOF frame writes from addr 0.
